// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: two-stage signed multiply-accumulate forming a TERMS-long dot product per block,
// with optional saturation, sticky per-block overflow, dstrb resync and a global clock enable.
module dct_mac_pipe #(
   parameter int A_W   = 8,
   parameter int B_W   = 12,
   parameter int ACC_W = 24,
   parameter int TERMS = 8,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             din_valid,
   input  logic             dstrb,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   output logic [ACC_W-1:0] result,
   output logic             result_valid,
   output logic             ovf
);
   localparam int P_W = A_W + B_W;
   localparam int CW  = $clog2(TERMS);
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   if (ACC_W < P_W || TERMS < 2) begin : g_bad_cfg
      $error("dct_mac_pipe: requires ACC_W >= A_W+B_W and TERMS >= 2");
   end

   logic [CW-1:0]    cnt_q, cnt_d, idx;
   logic             first, last;
   logic [P_W-1:0]   prod_q, prod_d;
   logic             p_vld_q, p_first_q, p_last_q;
   logic [ACC_W-1:0] acc_q, ext, base, raw, sum;
   logic             of, blk_ovf_q, blk_ovf_d;
   logic [ACC_W-1:0] result_q;
   logic             result_valid_q, ovf_q;

   // dstrb forces the current pair to be term 0, abandoning any partial block
   always_comb begin
      idx       = dstrb ? '0 : cnt_q;
      first     = idx == '0;
      last      = idx == CW'(TERMS - 1);
      cnt_d     = last ? '0 : idx + 1'b1;
      prod_d    = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
      ext       = ACC_W'($signed(prod_q));
      base      = p_first_q ? '0 : acc_q;
      raw       = base + ext;
      of        = !p_first_q && (acc_q[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_q[ACC_W-1]);
      sum       = (SAT != 0 && of) ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
      blk_ovf_d = (!p_first_q && blk_ovf_q) || of;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         prod_q         <= '0;
         p_vld_q        <= 1'b0;
         p_first_q      <= 1'b0;
         p_last_q       <= 1'b0;
         acc_q          <= '0;
         blk_ovf_q      <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         ovf_q          <= 1'b0;
      end else if (ena) begin
         p_vld_q        <= din_valid;
         result_valid_q <= p_vld_q && p_last_q;
         if (din_valid) begin
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            p_first_q <= first;
            p_last_q  <= last;
         end
         if (p_vld_q) begin
            acc_q     <= sum;
            blk_ovf_q <= blk_ovf_d;
            if (p_last_q) begin
               result_q <= sum;
               ovf_q    <= blk_ovf_d;
            end
         end
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign ovf          = ovf_q;
endmodule

// File: tb/tb_dct_mac_pipe.sv
// tb_dct_mac_pipe: drives default, ACC_W=20 saturating and ACC_W=20 wrapping instances with one
// shared stream; a reference model queues expected results that a monitor pops on result_valid.
module tb_dct_mac_pipe;
   logic        clk = 1'b0;
   logic        rst, ena, din_valid, dstrb;
   logic [7:0]  a;
   logic [11:0] b;
   logic [23:0] r0;
   logic [19:0] r1, r2;
   logic [2:0]  rv, ov;
   logic signed [63:0] res_o [3];

   always #5 clk = ~clk;

   dct_mac_pipe u_def (.clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .dstrb(dstrb),
      .a(a), .b(b), .result(r0), .result_valid(rv[0]), .ovf(ov[0]));
   dct_mac_pipe #(.ACC_W(20), .SAT(1)) u_sat (.clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid),
      .dstrb(dstrb), .a(a), .b(b), .result(r1), .result_valid(rv[1]), .ovf(ov[1]));
   dct_mac_pipe #(.ACC_W(20), .SAT(0)) u_wrp (.clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid),
      .dstrb(dstrb), .a(a), .b(b), .result(r2), .result_valid(rv[2]), .ovf(ov[2]));

   assign res_o[0] = 64'($signed(r0));
   assign res_o[1] = 64'($signed(r1));
   assign res_o[2] = 64'($signed(r2));

   typedef struct {
      longint res;
      bit     ovf;
      int     due;
   } exp_t;

   exp_t   sb [3][$];
   int     total = 0, bad = 0, ecyc = 0, mcnt = 0;
   longint macc [3];
   bit     mflag [3];
   int     accw [3] = '{24, 20, 20};
   bit     satc [3] = '{1'b0, 1'b1, 1'b0};

   // reference: range-checked arithmetic on longint, one expectation per completed block
   task automatic model_accept(input bit s, input int av, input int bv);
      int idx;
      longint p, sm, mx, mn;
      exp_t e;
      idx = s ? 0 : mcnt;
      p = longint'(av) * longint'(bv);
      for (int c = 0; c < 3; c++) begin
         mx = (64'sd1 <<< (accw[c] - 1)) - 1;
         mn = -mx - 1;
         if (idx == 0) begin
            macc[c] = p;
            mflag[c] = 1'b0;
         end else begin
            sm = macc[c] + p;
            if (sm > mx) begin
               mflag[c] = 1'b1;
               sm = satc[c] ? mx : sm - 2 * (mx + 1);
            end else if (sm < mn) begin
               mflag[c] = 1'b1;
               sm = satc[c] ? mn : sm + 2 * (mx + 1);
            end
            macc[c] = sm;
         end
         if (idx == 7) begin
            e.res = macc[c];
            e.ovf = mflag[c];
            e.due = ecyc + 2;
            sb[c].push_back(e);
         end
      end
      mcnt = (idx == 7) ? 0 : idx + 1;
   endtask

   task automatic drive(input bit e, input bit v, input bit s, input int av, input int bv);
      ena = e;
      din_valid = v;
      dstrb = s;
      a = av[7:0];
      b = bv[11:0];
      if (e && v && !rst) model_accept(s, av, bv);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic block(input int n, input bit strb, input int av, input int bv);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, strb && i == 0, av, bv);
   endtask

   task automatic monitor();
      bit en_s;
      exp_t e;
      forever begin
         @(posedge clk);
         en_s = ena && !rst;
         if (en_s) ecyc++;
         @(negedge clk);
         if (en_s) begin
            for (int c = 0; c < 3; c++) begin
               if (rv[c]) begin
                  total++;
                  if (sb[c].size() == 0) begin
                     bad++;
                     $display("FAIL pulse%0d: unexpected result_valid, result=%0d", c, res_o[c]);
                  end else begin
                     e = sb[c].pop_front();
                     if (res_o[c] !== e.res || ov[c] !== e.ovf || ecyc != e.due) begin
                        bad++;
                        $display("FAIL result%0d: got res=%0d ovf=%0b cyc=%0d, want res=%0d ovf=%0b cyc=%0d",
                                 c, res_o[c], ov[c], ecyc, e.res, e.ovf, e.due);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b1;
      din_valid = 1'b0;
      dstrb = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         total++;
         if (res_o[c] !== 64'sd0 || rv[c] !== 1'b0 || ov[c] !== 1'b0) begin
            bad++;
            $display("FAIL reset%0d: res=%0d rv=%0b ovf=%0b, want 0 0 0", c, res_o[c], rv[c], ov[c]);
         end
      end
      rst = 1'b0;
      mcnt = 0;
   endtask

   task automatic test_basic();
      block(8, 1'b1, 1, 1);
      idle(1);
      total++;
      if (rv[0] !== 1'b1 || res_o[0] !== 64'sd8) begin
         bad++;
         $display("FAIL latency: rv=%0b res=%0d two cycles after last term, want 1 8", rv[0], res_o[0]);
      end
      idle(1);
      total++;
      if (rv !== 3'b000) begin
         bad++;
         $display("FAIL pulse_width: rv=%b one cycle after pulse, want 000", rv);
      end
      block(16, 1'b1, 1, 1);
      idle(4);
   endtask

   task automatic test_signed();
      block(8, 1'b1, -128, 2047);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? 3 : -3, -5);
      idle(4);
   endtask

   task automatic test_sat();
      block(8, 1'b1, -128, -2048);
      block(8, 1'b0, 1, 1);
      idle(4);
   endtask

   task automatic test_stall();
      block(4, 1'b1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 4095)) - 2048);
         total++;
         if (rv !== 3'b000) begin
            bad++;
            $display("FAIL stall_hold0: rv=%b during stall, want 000", rv);
         end
      end
      block(4, 1'b0, 1, 1);
      idle(1);
      total++;
      if (rv[0] !== 1'b1 || res_o[0] !== 64'sd8) begin
         bad++;
         $display("FAIL stall_latency: rv=%0b res=%0d, want 1 8", rv[0], res_o[0]);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1, 77, 99);
         total++;
         if (rv !== 3'b111 || res_o[0] !== 64'sd8 || res_o[1] !== 64'sd8) begin
            bad++;
            $display("FAIL stall_hold1: rv=%b res=%0d/%0d, want 111 8/8", rv, res_o[0], res_o[1]);
         end
      end
      idle(1);
      total++;
      if (rv !== 3'b000) begin
         bad++;
         $display("FAIL stall_release: rv=%b, want 000", rv);
      end
      idle(3);
   endtask

   task automatic test_resync();
      block(5, 1'b1, 7, 7);
      block(4, 1'b1, 2, 1);
      drive(1'b1, 1'b0, 1'b1, 9, 9);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      block(4, 1'b0, 2, 1);
      idle(4);
   endtask

   task automatic test_reset_mid();
      block(3, 1'b1, 4, 4);
      rst = 1'b1;
      din_valid = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         total++;
         if (res_o[c] !== 64'sd0 || rv[c] !== 1'b0 || ov[c] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid%0d: res=%0d rv=%0b ovf=%0b, want 0 0 0", c, res_o[c], rv[c], ov[c]);
         end
      end
      rst = 1'b0;
      mcnt = 0;
      block(8, 1'b1, 5, -3);
      idle(4);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 4095)) - 2048);
      idle(4);
   endtask

   task automatic test_drain();
      for (int c = 0; c < 3; c++) begin
         total++;
         if (sb[c].size() != 0) begin
            bad++;
            $display("FAIL drain%0d: %0d expected results never delivered, want 0", c, sb[c].size());
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_signed();
      test_sat();
      test_stall();
      test_resync();
      test_reset_mid();
      test_random();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
